game_timer_bcd: RTL and testbench
=================================

Name: game_timer_bcd

Overview:
- Parametrised successor of the game countdown timer: an NDIG-digit BCD timer with a tenths digit, usable as countdown or count-up stopwatch.
- Adds a runtime-loadable preset, pause/resume, and an optional leading-zero blanked multiplexed 7-segment drive.
- Sits between the game FSM (start/pause/game_over) and the board's common-anode display.
- Reports expiry to the game FSM via time_up.

Parameters:
- NDIG, 4, number of BCD digits (2..8); digit 0 = tenths, digit 1 = seconds units, and so on.
- TICK_DIV, 10_000_000, CLK cycles per tenth-second tick (>=2).
- SCAN_W, 16, log2 of CLK cycles per display digit slot.
- DEF_PRESET, 16'h1200, preset loaded at reset: 4*NDIG bits, BCD, 120.0 s.
- BLANK_LZ, 1, 1 = blank leading zero digits above digit 1.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- start  in  1  level; start/resume/rearm
- pause  in  1  level; pause while RUN
- game_over  in  1  level; force DONE
- count_up  in  1  mode: 0 = down, 1 = up; sampled only in IDLE
- load_en  in  1  load preset (IDLE only)
- load_val  in  4*NDIG  BCD preset
- AN  out  NDIG  active-low one-hot digit enable
- Seg  out  7  active-low segments {g,f,e,d,c,b,a}
- Dp  out  1  active-low decimal point
- tick  out  1  one-cycle pulse per tenth counted
- time_up  out  1  high while in DONE

Behaviour:
- Reset (RESET=1 at posedge CLK):
  - state = IDLE; preset = DEF_PRESET; mode = down; value = DEF_PRESET; prescaler = 0; scan = 0.
  - Outputs: time_up = 0, tick = 0, AN = digit 0 active.
  - Reset mid-run abandons the count immediately.
- States: IDLE, RUN, PAUSED, DONE.
  - IDLE:
    - load_en=1: preset <= load_val, with any nibble >9 clamped to 9.
    - value shows preset in down mode and all zeros in up mode; it tracks the current count_up and preset every cycle.
    - start=1: latch mode, go to RUN.
  - RUN:
    - game_over -> DONE, value frozen.
    - Otherwise pause -> PAUSED.
    - Otherwise the prescaler counts.
  - PAUSED:
    - game_over -> DONE.
    - Otherwise start=1 and pause=0 -> RUN.
    - Prescaler and value hold.
  - DONE:
    - time_up = 1.
    - start=1 -> IDLE; the value reloads on the next cycle.
- Priority in RUN: game_over > pause > tick.
- Prescaler:
  - Counts 0..TICK_DIV-1, only in RUN.
  - At TICK_DIV-1 it wraps to 0 and tick=1 for that cycle; the value updates on the same edge.
  - Holds in PAUSED; cleared in IDLE and DONE.
  - The first tick comes TICK_DIV cycles after entering RUN.
- Down count:
  - BCD decrement with borrow ripple. A digit at 0 becomes 9 and borrows from the digit above.
  - If the tick takes the value to all zeros, state -> DONE on that same edge.
  - A value already zero at start goes to DONE on the first tick. The value never wraps below zero.
- Up count:
  - BCD increment with carry. A digit at 9 becomes 0 and carries.
  - When the new value equals preset -> DONE, holding preset.
  - Preset zero -> DONE on the first tick. All-nines with no match saturates and goes to DONE.
- Display:
  - Scan slot advances every 2^SCAN_W cycles in every state, cycling 0..NDIG-1.
  - AN bit k is low only in slot k. Seg uses the standard digit decode; e.g. 0 = 7'b1000000, 9 = 7'b0010000.
  - Dp is low only in slot 1.
  - With BLANK_LZ=1, digit k>=2 is blanked (Seg=7'h7F) if it and all higher digits are 0.
  - Decode is combinational from registered slot and value, so there is no glitch beyond one cycle.

Test Plan:
- Down basic (TICK_DIV=4, NDIG=4, preset 0003): start pulse → after 4 cycles tick and value=0002; 0001 at tick 2; at tick 3 value=0000 and time_up=1 on the same edge. start → IDLE, value=0003.
- Borrow ripple (preset 1000): after one tick value=0999; after a second tick 0998. Check leading-zero blanking: with value 0009, AN slots 2,3 give Seg=7'h7F and slot 1 shows '0' with Dp low.
- Up mode (count_up=1, preset 0012): from 0000, reaches 0012 at tick 12 → DONE holding 0012. Carry 0009→0010 is checked.
- Pause/resume: pause after 2 of 4 prescaler cycles, hold 10 cycles → value and prescaler frozen. Resume → next tick exactly 2 cycles later.
- game_over with pause also high in RUN at value 0057 → DONE, value frozen at 0057, time_up=1.
- load_val=16'h1A5F in IDLE → preset 1959. load_en in RUN is ignored. RESET asserted in RUN → IDLE, value=DEF_PRESET next cycle.

Source files
------------

// File: rtl/game_timer_bcd_if.sv
// Control/status and display bundle between the game FSM, the BCD timer and the display.
// Latency: none, plain wires.
// Backpressure: none; all signals are levels or single-cycle pulses.
//   master (game FSM side): drives start/pause/game_over/count_up/load_en/load_val,
//                           observes AN/Seg/Dp/tick/time_up
//   slave  (timer side)   : the reverse
interface game_timer_bcd_if #(
    parameter int NDIG = 4
);
    logic                  start;
    logic                  pause;
    logic                  game_over;
    logic                  count_up;
    logic                  load_en;
    logic [4*NDIG-1:0]     load_val;
    logic [NDIG-1:0]       AN;
    logic [6:0]            Seg;
    logic                  Dp;
    logic                  tick;
    logic                  time_up;

    modport master (
        output start, pause, game_over, count_up, load_en, load_val,
        input  AN, Seg, Dp, tick, time_up
    );

    modport slave (
        input  start, pause, game_over, count_up, load_en, load_val,
        output AN, Seg, Dp, tick, time_up
    );
endinterface

// File: rtl/game_timer_bcd.sv
// NDIG-digit BCD game timer (tenths resolution), countdown or count-up, with muxed 7-seg drive.
// Latency: tick/value/time_up update on the same edge; display decode is combinational from registers.
// Backpressure: none; control inputs are levels sampled every CLK edge.
//   CLK, RESET : clock and synchronous active-high reset
//   bus        : slave side of game_timer_bcd_if (start/pause/game_over/count_up/load_en/load_val in;
//                AN/Seg/Dp active-low display drive, tick pulse, time_up level out)
module game_timer_bcd #(
    parameter int                NDIG       = 4,
    parameter int                TICK_DIV   = 10_000_000,
    parameter int                SCAN_W     = 16,
    parameter logic [4*NDIG-1:0] DEF_PRESET = (4*NDIG)'(16'h1200),
    parameter bit                BLANK_LZ   = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    game_timer_bcd_if.slave   bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(NDIG);
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]     SLOT_LAST  = SW'(NDIG - 1);
    localparam logic [4*NDIG-1:0] ALL_NINES  = {NDIG{4'h9}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_e;

    state_e             state;
    logic [4*NDIG-1:0]  preset;
    logic [4*NDIG-1:0]  value;
    logic               mode_up;
    logic [PW-1:0]      presc;
    logic [SCAN_W-1:0]  scan_div;
    logic [SW-1:0]      slot;
    logic               tick_r;

    logic [4*NDIG-1:0]  val_dec;
    logic [4*NDIG-1:0]  val_inc;
    logic [4*NDIG-1:0]  load_clamped;

    // BCD +/-1 with ripple carry/borrow, and per-nibble clamp of the loaded preset.
    always_comb begin
        logic borrow;
        logic carry;
        logic [3:0] nib;
        val_dec      = value;
        val_inc      = value;
        load_clamped = '0;
        borrow       = 1'b1;
        carry        = 1'b1;
        nib          = '0;
        for (int k = 0; k < NDIG; k++) begin
            nib = value[4*k +: 4];
            if (borrow) begin
                if (nib == 4'd0) begin
                    val_dec[4*k +: 4] = 4'd9;
                end else begin
                    val_dec[4*k +: 4] = nib - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (carry) begin
                if (nib >= 4'd9) begin
                    val_inc[4*k +: 4] = 4'd0;
                end else begin
                    val_inc[4*k +: 4] = nib + 4'd1;
                    carry = 1'b0;
                end
            end
            nib = bus.load_val[4*k +: 4];
            load_clamped[4*k +: 4] = (nib > 4'd9) ? 4'd9 : nib;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            preset   <= DEF_PRESET;
            value    <= DEF_PRESET;
            mode_up  <= 1'b0;
            presc    <= '0;
            scan_div <= '0;
            slot     <= '0;
            tick_r   <= 1'b0;
        end else begin
            tick_r   <= 1'b0;
            scan_div <= scan_div + SCAN_W'(1);
            if (&scan_div) begin
                slot <= (slot == SLOT_LAST) ? '0 : slot + SW'(1);
            end
            case (state)
                S_IDLE: begin
                    presc <= '0;
                    if (bus.load_en) begin
                        preset <= load_clamped;
                    end
                    // Value follows the registered preset, so a load shows up one cycle later.
                    value <= bus.count_up ? '0 : preset;
                    if (bus.start) begin
                        mode_up <= bus.count_up;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.game_over) begin
                        state <= S_DONE;
                        presc <= '0;
                    end else if (bus.pause) begin
                        state <= S_PAUSED;
                    end else if (presc == PRESC_LAST) begin
                        presc  <= '0;
                        tick_r <= 1'b1;
                        if (!mode_up) begin
                            // Never wraps below zero: a zero value just expires.
                            if (value == '0) begin
                                state <= S_DONE;
                            end else begin
                                value <= val_dec;
                                if (val_dec == '0) begin
                                    state <= S_DONE;
                                end
                            end
                        end else begin
                            if (preset == '0) begin
                                value <= preset;
                                state <= S_DONE;
                            end else if (value == ALL_NINES) begin
                                state <= S_DONE;
                            end else begin
                                value <= val_inc;
                                if (val_inc == preset) begin
                                    state <= S_DONE;
                                end
                            end
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                S_PAUSED: begin
                    if (bus.game_over) begin
                        state <= S_DONE;
                    end else if (bus.start && !bus.pause) begin
                        state <= S_RUN;
                    end
                end
                S_DONE: begin
                    presc <= '0;
                    if (bus.start) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Display decode: digit of the current slot, with leading-zero blanking above the seconds digit.
    always_comb begin
        logic [NDIG-1:0] lz;
        logic            above;
        logic [3:0]      dig;
        lz    = '0;
        above = 1'b1;
        for (int k = NDIG - 1; k >= 2; k--) begin
            above = above && (value[4*k +: 4] == 4'd0);
            lz[k] = above;
        end
        dig = value[4*int'(slot) +: 4];
        case (dig)
            4'd0:    bus.Seg = 7'b1000000;
            4'd1:    bus.Seg = 7'b1111001;
            4'd2:    bus.Seg = 7'b0100100;
            4'd3:    bus.Seg = 7'b0110000;
            4'd4:    bus.Seg = 7'b0011001;
            4'd5:    bus.Seg = 7'b0010010;
            4'd6:    bus.Seg = 7'b0000010;
            4'd7:    bus.Seg = 7'b1111000;
            4'd8:    bus.Seg = 7'b0000000;
            4'd9:    bus.Seg = 7'b0010000;
            default: bus.Seg = 7'h7F;
        endcase
        if (BLANK_LZ && lz[slot]) begin
            bus.Seg = 7'h7F;
        end
        bus.AN       = '1;
        bus.AN[slot] = 1'b0;
        bus.Dp       = (slot != SW'(1));
    end

    assign bus.tick    = tick_r;
    assign bus.time_up = (state == S_DONE);
endmodule

// File: tb/tb_game_timer_bcd.sv
module tb_game_timer_bcd;
    localparam int          NDIG       = 4;
    localparam int          TICK_DIV   = 6;
    localparam int          SCAN_W     = 1;
    localparam logic [15:0] DEF_PRESET = 16'h0105;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    game_timer_bcd_if #(.NDIG(NDIG)) bus ();

    game_timer_bcd #(
        .NDIG(NDIG), .TICK_DIV(TICK_DIV), .SCAN_W(SCAN_W),
        .DEF_PRESET(DEF_PRESET), .BLANK_LZ(1'b1)
    ) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NDIG-1:0] an;
        logic [6:0]      seg;
        logic            dp;
        logic            tick;
        logic            time_up;
        int              val;
    } exp_t;

    typedef enum {M_IDLE, M_RUN, M_PAUSED, M_DONE} mstate_e;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic int bcd_to_int_clamped(input logic [15:0] b);
        int r = 0;
        for (int k = 0; k < NDIG; k++) begin
            int n = int'(b[4*k +: 4]);
            if (n > 9) n = 9;
            r += n * pow10(k);
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  default: return 7'h10;
        endcase
    endfunction

    // Reference model: value held as an integer count of tenths, prescaler as cycles counted in RUN.
    mstate_e m_st;
    int      m_val, m_pre, m_pc, m_cyc;
    bit      m_up, m_tick;

    always @(posedge CLK) begin : model
        exp_t e;
        int   slot, d;
        if (RESET) begin
            m_st = M_IDLE; m_pre = bcd_to_int_clamped(DEF_PRESET); m_val = m_pre;
            m_up = 0; m_pc = 0; m_cyc = 0; m_tick = 0;
        end else begin
            m_cyc++;
            m_tick = 0;
            case (m_st)
                M_IDLE: begin
                    m_pc  = 0;
                    m_val = bus.count_up ? 0 : m_pre;
                    if (bus.load_en) m_pre = bcd_to_int_clamped(bus.load_val);
                    if (bus.start) begin m_up = bus.count_up; m_st = M_RUN; end
                end
                M_RUN: begin
                    if (bus.game_over) m_st = M_DONE;
                    else if (bus.pause) m_st = M_PAUSED;
                    else if (m_pc == TICK_DIV - 1) begin
                        m_pc = 0; m_tick = 1;
                        if (!m_up) begin
                            if (m_val > 0) m_val--;
                            if (m_val == 0) m_st = M_DONE;
                        end else if (m_pre == 0) begin
                            m_val = 0; m_st = M_DONE;
                        end else if (m_val == pow10(NDIG) - 1) begin
                            m_st = M_DONE;
                        end else begin
                            m_val++;
                            if (m_val == m_pre) m_st = M_DONE;
                        end
                    end else m_pc++;
                end
                M_PAUSED: begin
                    if (bus.game_over) m_st = M_DONE;
                    else if (bus.start && !bus.pause) m_st = M_RUN;
                end
                default: begin
                    m_pc = 0;
                    if (bus.start) m_st = M_IDLE;
                end
            endcase
        end
        slot = (m_cyc / (1 << SCAN_W)) % NDIG;
        d    = (m_val / pow10(slot)) % 10;
        e.an        = '1;
        e.an[slot]  = 1'b0;
        e.seg       = (slot >= 2 && m_val / pow10(slot) == 0) ? 7'h7F : seg_of(d);
        e.dp        = (slot != 1);
        e.tick      = m_tick;
        e.time_up   = (m_st == M_DONE);
        e.val       = m_val;
        exp_q.push_back(e);
    end

    // Monitor: every cycle the DUT presents one display slot plus status; compare against the model.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus.AN, bus.Seg, bus.Dp} !== {e.an, e.seg, e.dp}) begin
                n_bad++;
                $display("FAIL disp t=%0t value=%0d AN/Seg/Dp got %b/%b/%b want %b/%b/%b",
                         $time, e.val, bus.AN, bus.Seg, bus.Dp, e.an, e.seg, e.dp);
            end
            n_cmp++;
            if ({bus.tick, bus.time_up} !== {e.tick, e.time_up}) begin
                n_bad++;
                $display("FAIL status t=%0t value=%0d tick/time_up got %b/%b want %b/%b",
                         $time, e.val, bus.tick, bus.time_up, e.tick, e.time_up);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; idle(1); bus.start = 1'b0;
    endtask

    task automatic pulse_game_over();
        bus.game_over = 1'b1; idle(1); bus.game_over = 1'b0;
    endtask

    task automatic load(input logic [15:0] v);
        bus.load_en = 1'b1; bus.load_val = v; idle(1); bus.load_en = 1'b0; idle(2);
    endtask

    initial begin
        bus.start = 0; bus.pause = 0; bus.game_over = 0; bus.count_up = 0;
        bus.load_en = 0; bus.load_val = '0;
        RESET = 1'b1;
        idle(3);
        RESET = 1'b0;
        idle(4);

        // Down count 0003 to expiry, then rearm.
        load(16'h0003); pulse_start(); idle(3 * TICK_DIV + 12); pulse_start(); idle(10);

        // Borrow ripple 1000 -> 0999 -> 0998, stop, then blanking of 0009.
        load(16'h1000); pulse_start(); idle(2 * TICK_DIV + 10);
        pulse_game_over(); idle(10); pulse_start(); idle(4);
        load(16'h0009); idle(16);

        // Up mode to 0012 (carry 0009 -> 0010); mode is latched at start.
        bus.count_up = 1'b1; load(16'h0012); pulse_start(); bus.count_up = 1'b0;
        idle(12 * TICK_DIV + 10); pulse_start(); idle(4);
        bus.count_up = 1'b1; idle(6); bus.count_up = 1'b0; idle(2);

        // Pause mid-prescale, hold, resume; then game_over with pause also high.
        load(16'h0060); pulse_start(); idle(TICK_DIV + 2);
        bus.pause = 1'b1; idle(10); bus.pause = 1'b0;
        pulse_start(); idle(3 * TICK_DIV + 1);
        bus.pause = 1'b1; bus.game_over = 1'b1; idle(1);
        bus.pause = 1'b0; bus.game_over = 1'b0; idle(12); pulse_start(); idle(4);

        // Preset zero in both modes expires on the first tick.
        load(16'h0000); pulse_start(); idle(TICK_DIV + 4); pulse_start(); idle(2);
        bus.count_up = 1'b1; pulse_start(); bus.count_up = 1'b0;
        idle(TICK_DIV + 4); pulse_start(); idle(2);

        // Clamped load, load ignored outside IDLE, reset mid-run.
        load(16'h1A5F); idle(12); pulse_start(); idle(3);
        bus.load_en = 1'b1; bus.load_val = 16'h0002; idle(1); bus.load_en = 1'b0;
        pulse_game_over(); idle(5); pulse_start(); idle(12);
        pulse_start(); idle(TICK_DIV + 3);
        RESET = 1'b1; idle(1); RESET = 1'b0; idle(12);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.pause     = ($urandom_range(0, 9) == 0);
            bus.game_over = ($urandom_range(0, 59) == 0);
            bus.count_up  = $urandom_range(0, 1);
            bus.load_en   = ($urandom_range(0, 9) == 0);
            bus.load_val  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0025));
            RESET         = ($urandom_range(0, 499) == 0);
            idle(1);
        end
        bus.start = 0; bus.pause = 0; bus.game_over = 0; bus.load_en = 0; RESET = 1'b0;
        idle(4);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain queue size got %0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
